sa_skew_feeder: RTL
===================

// Module: sa_skew_feeder
// PURPOSE
//  Synthesizable operand front-end for the HPE x VPE systolic array. Accepts one
//  A row-vector and one B column-vector per beat (valid/ready) and drives the
//  array edge buses AA/BB with per-lane diagonal skew.
//  Tracks tile boundaries, pads with zero bubbles and flushes after the last beat.
//  Pulses tile_done when the tile's final lane plus DRAIN cycles have been issued.
// PARAMETERS
//  WIDTH   16   operand width per lane (bits)
//  HPE     8    A lanes (array rows)
//  VPE     8    B lanes (array columns)
//  KMAX    256  max beats per tile; beat number KMAX is forced to be last
//  DRAIN   0    extra zero cycles appended to the flush (array pipeline depth)
// PORTS
//  CLK        in   1          clock, all state on rising edge
//  RST        in   1          asynchronous active-low reset
//  skew_en    in   1          1: lane i delayed i cycles; 0: all lanes aligned
//  in_valid   in   1          beat present
//  in_ready   out  1          feeder accepts beat (accept = in_valid & in_ready)
//  in_a       in   WIDTH*HPE  A lanes, lane i = [i*WIDTH +: WIDTH]
//  in_b       in   WIDTH*VPE  B lanes, lane j = [j*WIDTH +: WIDTH]
//  in_last    in   1          accepted beat closes the tile
//  AA         out  WIDTH*HPE  skewed A to array, same lane packing
//  BB         out  WIDTH*VPE  skewed B to array, same lane packing
//  out_valid  out  1          lane 0 of AA/BB carries a real beat
//  tile_done  out  1          one-cycle pulse, tile fully issued
//  beat_cnt   out  $clog2(KMAX+1)  beats accepted in current/last tile
//  err_long   out  1          sticky: a tile hit KMAX without in_last
// BEHAVIOUR
//  Reset (RST=0, async): AA=BB=0, all delay stages 0, out_valid=0, tile_done=0,
//   beat_cnt=0, err_long=0, state IDLE, in_ready=1 after release.
//  Latency: beat accepted at edge t -> A lane i on AA after edge t+1+i, B lane j
//   on BB after edge t+1+j (skew mode); all lanes after edge t+1 (aligned mode).
//  Lanes not carrying a beat output 0 (bubble); no stale data ever re-emitted.
//  Let L = max(HPE,VPE) in skew mode, 1 in aligned mode.
//  FSM: IDLE  -- accept, in_last=0 -> STREAM; accept with in_last -> FLUSH.
//       STREAM-- accept with in_last, or beat_cnt reaching KMAX -> FLUSH;
//               in_valid=0 inserts a bubble, stays STREAM.
//       FLUSH -- in_ready=0; zeros shifted in; tile_done high in the single
//               cycle after edge t_last+L+DRAIN; next edge -> IDLE.
//  in_ready=1 in IDLE and STREAM, 0 throughout FLUSH incl. tile_done cycle.
//  skew_en sampled on first accepted beat of a tile; changes mid-tile ignored.
//  beat_cnt: cleared on first beat of new tile then set to 1; +1 per accepted
//   beat; holds value through FLUSH and IDLE until next tile starts.
//  Forced last at beat KMAX sets err_long (sticky until reset); in_last on that
//   same beat does not set err_long.
//  Single-beat tile (in_last on first beat) legal: IDLE -> FLUSH directly.
//  HPE != VPE: shorter side lanes simply finish early; flush uses L.
//  Reset mid-tile: pipeline cleared immediately, no tile_done, partial tile lost.
// TESTING (WIDTH=16, HPE=VPE=4, KMAX=8, DRAIN=0)
//  1 skew_en=1, 1 beat a=0x0004_0003_0002_0001 last=1 @t -> AA lane i=i+1 after
//    edge t+1+i, other cycles 0; tile_done after edge t+4; in_ready=0 t+1..t+4.
//  2 3 back-to-back beats, in_valid low 1 cycle between beat 2 and 3 -> zero
//    bubble on each lane at its skew offset, beat_cnt=3, out_valid has 1-cycle gap.
//  3 skew_en=0, single beat last -> all 4 lanes after edge t+1, tile_done after
//    edge t+1; toggling skew_en mid-tile leaves timing unchanged.
//  4 9 beats with no in_last -> beat 8 forced last, err_long=1, in_ready=0 on
//    beat 9, beat_cnt=8; beat 9 accepted as first beat of next tile.
//  5 RST=0 asynchronously mid-STREAM with data in pipeline -> AA/BB=0 at once,
//    no tile_done, beat_cnt=0, in_ready=1 after release.
//  6 HPE=4,VPE=2, DRAIN=2, single beat -> BB lanes done after t+2, tile_done
//    after edge t+6.

Source files
------------

// File: rtl/sa_skew_feeder.sv
// Operand front-end for the HPE x VPE systolic array: accepts A/B vector beats,
// drives the array edges with per-lane diagonal skew, zero bubbles and a tile flush.

module sa_skew_feeder #(
    parameter int WIDTH = 16,
    parameter int HPE   = 8,
    parameter int VPE   = 8,
    parameter int KMAX  = 256,
    parameter int DRAIN = 0
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      skew_en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*HPE-1:0]      in_a,
    input  logic [WIDTH*VPE-1:0]      in_b,
    input  logic                      in_last,
    output logic [WIDTH*HPE-1:0]      AA,
    output logic [WIDTH*VPE-1:0]      BB,
    output logic                      out_valid,
    output logic                      tile_done,
    output logic [$clog2(KMAX+1)-1:0] beat_cnt,
    output logic                      err_long
);
    localparam int LMAX = (HPE > VPE) ? HPE : VPE;
    localparam int CW   = $clog2(KMAX + 1);
    localparam int FW   = $clog2(LMAX + DRAIN + 1);
    localparam logic [CW-1:0] KMAX_C = CW'(KMAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_FLUSH
    } state_e;

    state_e          state_q, state_d;
    logic            skew_q, skew_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            err_long_q, err_long_d;
    logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [1:0]      valid_pipe_q, valid_pipe_d;

    logic            accept;
    logic            cur_skew;
    logic [CW-1:0]   cnt_next;
    logic [FW-1:0]   flush_len;

    assign in_ready  = (state_q != ST_FLUSH);
    assign accept    = in_valid & in_ready;
    // The mode is latched by the first beat of a tile; later beats follow it.
    assign cur_skew  = (state_q == ST_IDLE) ? skew_en : skew_q;
    assign cnt_next  = (state_q == ST_IDLE) ? CW'(1) : beat_cnt_q + CW'(1);
    assign flush_len = skew_q ? FW'(LMAX + DRAIN) : FW'(1 + DRAIN);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        skew_d       = skew_q;
        beat_cnt_d   = beat_cnt_q;
        err_long_d   = err_long_q;
        flush_cnt_d  = flush_cnt_q;
        valid_pipe_d = {valid_pipe_q[0], accept};
        tile_done    = 1'b0;
        case (state_q)
            ST_IDLE, ST_STREAM: begin
                if (accept) begin
                    beat_cnt_d = cnt_next;
                    if (state_q == ST_IDLE) skew_d = skew_en;
                    if (in_last || cnt_next == KMAX_C) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = '0;
                        if (!in_last) err_long_d = 1'b1;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == flush_len) begin
                    tile_done = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            skew_q       <= 1'b0;
            beat_cnt_q   <= '0;
            err_long_q   <= 1'b0;
            flush_cnt_q  <= '0;
            valid_pipe_q <= '0;
        end else begin
            state_q      <= state_d;
            skew_q       <= skew_d;
            beat_cnt_q   <= beat_cnt_d;
            err_long_q   <= err_long_d;
            flush_cnt_q  <= flush_cnt_d;
            valid_pipe_q <= valid_pipe_d;
        end
    end

    assign out_valid = valid_pipe_q[1];
    assign beat_cnt  = beat_cnt_q;
    assign err_long  = err_long_q;

    // Lane i is an (i+2)-deep shift line tapped at its end: skewed data enters
    // at stage 0, aligned data at stage i, so both modes share one output tap.
    for (genvar i = 0; i < HPE; i++) begin : g_a_lane
        logic [WIDTH-1:0] stage_q [i+2];
        logic [WIDTH-1:0] stage_d [i+2];

        always_comb begin
            stage_d[0] = '0;
            for (int k = 1; k <= i + 1; k++) stage_d[k] = stage_q[k-1];
            if (accept) begin
                if (cur_skew) stage_d[0] = in_a[i*WIDTH +: WIDTH];
                else          stage_d[i] = in_a[i*WIDTH +: WIDTH];
            end
        end

        // NOTE: the delay lines are reset like control state, so a bubble can never replay old data.
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                for (int k = 0; k <= i + 1; k++) stage_q[k] <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign AA[i*WIDTH +: WIDTH] = stage_q[i+1];
    end

    for (genvar j = 0; j < VPE; j++) begin : g_b_lane
        logic [WIDTH-1:0] stage_q [j+2];
        logic [WIDTH-1:0] stage_d [j+2];

        always_comb begin
            stage_d[0] = '0;
            for (int k = 1; k <= j + 1; k++) stage_d[k] = stage_q[k-1];
            if (accept) begin
                if (cur_skew) stage_d[0] = in_b[j*WIDTH +: WIDTH];
                else          stage_d[j] = in_b[j*WIDTH +: WIDTH];
            end
        end

        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                for (int k = 0; k <= j + 1; k++) stage_q[k] <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign BB[j*WIDTH +: WIDTH] = stage_q[j+1];
    end

endmodule
